// File: rtl/clock_pkg.sv
// Shared types and constants for the alarm-clock timekeeping engine.
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZED = 2'd2
  } alarm_state_t;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  localparam logic [1:0] SEL_NONE  = 2'd0;
  localparam logic [1:0] SEL_TIME  = 2'd1;
  localparam logic [1:0] SEL_ALARM = 2'd2;

  // Maps an internal 0-23 hour onto the 1-12 dial.
  function automatic logic [HOUR_W-1:0] to_12h(input logic [HOUR_W-1:0] h);
    if (h == '0) return HOUR_W'(12);
    else if (h > HOUR_W'(12)) return h - HOUR_W'(12);
    else return h;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD up-counter with synchronous clear; carry is the combinational wrap strobe.
module mod_counter #(
  parameter int MOD = 60,
  parameter int W   = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] value,
  output logic         carry
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  assign carry = inc && (value == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      value <= '0;
    end else if (inc) begin
      value <= carry ? '0 : value + W'(1);
    end
  end

endmodule

// File: rtl/alarm_clock_core.sv
// Timekeeping and alarm engine: prescaled sec/min/hour chain, settable time
// and alarm, 12/24-hour presentation and a ring/snooze alarm state machine.
module alarm_clock_core
  import clock_pkg::*;
#(
  parameter int TICK_DIV   = 100_000_000,
  parameter int HOUR_24    = 1,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_MIN = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [1:0]        set_sel,
  input  logic              inc_min,
  input  logic              inc_hour,
  input  logic              alarm_en,
  input  logic              snooze,
  input  logic              alarm_off,
  output logic [SEC_W-1:0]  sec,
  output logic [MIN_W-1:0]  min,
  output logic [HOUR_W-1:0] hour,
  output logic              pm,
  output logic [MIN_W-1:0]  alarm_min,
  output logic [HOUR_W-1:0] alarm_hour,
  output logic              sec_tick,
  output logic              min_tick,
  output logic              hour_tick,
  output logic              alarm_active
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [7:0] RING_LAST   = 8'(RING_SEC - 1);
  localparam logic [5:0] SNOOZE_LAST = 6'(SNOOZE_MIN - 1);

  logic              set_time;
  logic              set_alarm;
  logic              presc_carry;
  logic              sec_carry;
  logic              min_carry;
  logic [PW-1:0]     unused_presc_val;
  logic              unused_hour_carry;
  logic              unused_amin_carry;
  logic              unused_ahour_carry;
  logic [HOUR_W-1:0] hour_q;
  logic [HOUR_W-1:0] alarm_hour_q;

  assign set_time  = (set_sel == SEL_TIME);
  assign set_alarm = (set_sel == SEL_ALARM);

  mod_counter #(.MOD(TICK_DIV), .W(PW)) u_presc (
    .clk(clk), .rst(rst), .clr(set_time), .inc(run && !set_time),
    .value(unused_presc_val), .carry(presc_carry)
  );

  mod_counter #(.MOD(60), .W(SEC_W)) u_sec (
    .clk(clk), .rst(rst), .clr(set_time), .inc(presc_carry),
    .value(sec), .carry(sec_carry)
  );

  // In set-time mode the minute/hour fields step independently, so the
  // minute wrap must never reach the hour counter.
  mod_counter #(.MOD(60), .W(MIN_W)) u_min (
    .clk(clk), .rst(rst), .clr(1'b0), .inc(set_time ? inc_min : sec_carry),
    .value(min), .carry(min_carry)
  );

  mod_counter #(.MOD(24), .W(HOUR_W)) u_hour (
    .clk(clk), .rst(rst), .clr(1'b0), .inc(set_time ? inc_hour : min_carry),
    .value(hour_q), .carry(unused_hour_carry)
  );

  mod_counter #(.MOD(60), .W(MIN_W)) u_alarm_min (
    .clk(clk), .rst(rst), .clr(1'b0), .inc(set_alarm && inc_min),
    .value(alarm_min), .carry(unused_amin_carry)
  );

  mod_counter #(.MOD(24), .W(HOUR_W)) u_alarm_hour (
    .clk(clk), .rst(rst), .clr(1'b0), .inc(set_alarm && inc_hour),
    .value(alarm_hour_q), .carry(unused_ahour_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sec_tick  <= 1'b0;
      min_tick  <= 1'b0;
      hour_tick <= 1'b0;
    end else begin
      sec_tick  <= presc_carry;
      min_tick  <= sec_carry;
      hour_tick <= min_carry && !set_time;
    end
  end

  assign hour       = (HOUR_24 != 0) ? hour_q : to_12h(hour_q);
  assign alarm_hour = (HOUR_24 != 0) ? alarm_hour_q : to_12h(alarm_hour_q);
  assign pm         = (hour_q >= HOUR_W'(12));

  // Alarm FSM works off the registered ticks, so a match is seen in the
  // cycle where the new 00 seconds value is already visible.
  alarm_state_t state_q, state_d;
  logic [7:0]   ring_q, ring_d;
  logic [5:0]   snz_q, snz_d;
  logic         match;

  assign match = sec_tick && (sec == '0) && !set_time && alarm_en &&
                 (hour_q == alarm_hour_q) && (min == alarm_min);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ring_q  <= '0;
      snz_q   <= '0;
    end else begin
      state_q <= state_d;
      ring_q  <= ring_d;
      snz_q   <= snz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ring_d  = ring_q;
    snz_d   = snz_q;
    case (state_q)
      IDLE: begin
        if (match) begin
          state_d = RINGING;
          ring_d  = '0;
        end
      end
      RINGING: begin
        if (alarm_off || !alarm_en || (sec_tick && ring_q == RING_LAST)) begin
          state_d = IDLE;
        end else if (snooze) begin
          state_d = SNOOZED;
          snz_d   = '0;
        end else if (sec_tick) begin
          ring_d = ring_q + 8'd1;
        end
      end
      SNOOZED: begin
        if (alarm_off || !alarm_en) begin
          state_d = IDLE;
        end else if (min_tick) begin
          if (snz_q == SNOOZE_LAST) begin
            state_d = RINGING;
            ring_d  = '0;
          end else begin
            snz_d = snz_q + 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign alarm_active = (state_q == RINGING);

endmodule

// File: tb/tb_alarm_clock_core.sv
// Bench for alarm_clock_core: vector table, hand-built corner sequences and
// a randomized run against a seconds-of-day reference model.
module tb_alarm_clock_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic [1:0] set_sel = 2'd0;
  logic       inc_min = 1'b0, inc_hour = 1'b0, alarm_en = 1'b0;
  logic       snooze = 1'b0, alarm_off = 1'b0;

  logic [5:0] sec, min, amin, sec12, min12, amin12;
  logic [4:0] hour24, ahour24, hour12, ahour12;
  logic       pm24, st, mt, ht, aa, pm12, st12, mt12, ht12, aa12;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alarm_clock_core #(.TICK_DIV(4), .HOUR_24(1), .RING_SEC(3), .SNOOZE_MIN(1)) u_dut24 (
    .clk(clk), .rst(rst), .run(run), .set_sel(set_sel), .inc_min(inc_min),
    .inc_hour(inc_hour), .alarm_en(alarm_en), .snooze(snooze), .alarm_off(alarm_off),
    .sec(sec), .min(min), .hour(hour24), .pm(pm24), .alarm_min(amin),
    .alarm_hour(ahour24), .sec_tick(st), .min_tick(mt), .hour_tick(ht),
    .alarm_active(aa)
  );

  alarm_clock_core #(.TICK_DIV(4), .HOUR_24(0), .RING_SEC(3), .SNOOZE_MIN(1)) u_dut12 (
    .clk(clk), .rst(rst), .run(run), .set_sel(set_sel), .inc_min(inc_min),
    .inc_hour(inc_hour), .alarm_en(alarm_en), .snooze(snooze), .alarm_off(alarm_off),
    .sec(sec12), .min(min12), .hour(hour12), .pm(pm12), .alarm_min(amin12),
    .alarm_hour(ahour12), .sec_tick(st12), .min_tick(mt12), .hour_tick(ht12),
    .alarm_active(aa12)
  );

  // Reference model: time as seconds of day, alarm as minutes of day,
  // alarm behaviour as countdowns of remaining ring seconds / snooze minutes.
  int m_p, m_t, m_am, m_mode, m_ring_left, m_snz_left;
  bit m_st, m_mt, m_ht;

  function automatic int h12(input int h);
    if (h == 0) return 12;
    if (h > 12) return h - 12;
    return h;
  endfunction

  function void model_step();
    bit set_t, set_a, match;
    int h, mi;
    if (rst) begin
      m_p = 0; m_t = 0; m_am = 0; m_mode = 0; m_ring_left = 0; m_snz_left = 0;
      m_st = 0; m_mt = 0; m_ht = 0;
      return;
    end
    set_t = (set_sel == 2'd1);
    set_a = (set_sel == 2'd2);
    match = m_st && (m_t % 60 == 0) && !set_t && alarm_en && (m_t / 60 == m_am);
    case (m_mode)
      0: if (match) begin m_mode = 1; m_ring_left = 3; end
      1: begin
        if (alarm_off || !alarm_en) m_mode = 0;
        else if (m_st && m_ring_left == 1) m_mode = 0;
        else if (snooze) begin m_mode = 2; m_snz_left = 1; end
        else if (m_st) m_ring_left--;
      end
      default: begin
        if (alarm_off || !alarm_en) m_mode = 0;
        else if (m_mt) begin
          if (m_snz_left == 1) begin m_mode = 1; m_ring_left = 3; end
          else m_snz_left--;
        end
      end
    endcase
    m_st = 0; m_mt = 0; m_ht = 0;
    if (set_t) begin
      m_p = 0;
      h = m_t / 3600;
      mi = (m_t / 60) % 60;
      if (inc_min) mi = (mi + 1) % 60;
      if (inc_hour) h = (h + 1) % 24;
      m_t = h * 3600 + mi * 60;
    end else if (run) begin
      if (m_p == 3) begin
        m_p = 0;
        m_t = (m_t + 1) % 86400;
        m_st = 1;
        m_mt = (m_t % 60 == 0);
        m_ht = (m_t % 3600 == 0);
      end else begin
        m_p++;
      end
    end
    if (set_a) begin
      h = m_am / 60;
      mi = m_am % 60;
      if (inc_min) mi = (mi + 1) % 60;
      if (inc_hour) h = (h + 1) % 24;
      m_am = h * 60 + mi;
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic ru, input logic [1:0] s,
                      input logic im, input logic ih, input logic en,
                      input logic sn, input logic of);
    rst = r; run = ru; set_sel = s; inc_min = im; inc_hour = ih;
    alarm_en = en; snooze = sn; alarm_off = of;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic check_model();
    chk("sec", sec, m_t % 60);
    chk("min", min, (m_t / 60) % 60);
    chk("hour24", hour24, m_t / 3600);
    chk("pm24", pm24, int'(m_t / 3600 >= 12));
    chk("amin", amin, m_am % 60);
    chk("ahour24", ahour24, m_am / 60);
    chk("sec_tick", st, m_st);
    chk("min_tick", mt, m_mt);
    chk("hour_tick", ht, m_ht);
    chk("alarm_active", aa, int'(m_mode == 1));
    chk("sec12", sec12, m_t % 60);
    chk("min12", min12, (m_t / 60) % 60);
    chk("hour12", hour12, h12(m_t / 3600));
    chk("pm12", pm12, int'(m_t / 3600 >= 12));
    chk("amin12", amin12, m_am % 60);
    chk("ahour12", ahour12, h12(m_am / 60));
    chk("sec_tick12", st12, m_st);
    chk("min_tick12", mt12, m_mt);
    chk("hour_tick12", ht12, m_ht);
    chk("alarm_active12", aa12, int'(m_mode == 1));
  endtask

  typedef struct {
    logic       rst, run;
    logic [1:0] sel;
    logic       im, ih;
    int         e_sec, e_min, e_hour, e_st, e_amin, e_ahour;
  } vec_t;

  vec_t vt[13];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, nst, nmt, bad_seq, tick_cyc, rise, fall, cyc, mt_cyc, rering, any_tick;
    int r;
    logic [1:0] rs;

    // rst run sel im ih | sec min hour sec_tick amin ahour
    vt[0]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0};
    vt[1]  = '{1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 0, 0, 1, 0, 0, 0};
    vt[2]  = '{1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 0, 1, 1, 0, 0, 0};
    vt[3]  = '{1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 0, 2, 2, 0, 0, 0};
    vt[4]  = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 0, 2, 2, 0, 0, 0};
    vt[5]  = '{1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 0, 2, 2, 0, 0, 0};
    vt[6]  = '{1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 0, 2, 2, 0, 1, 1};
    vt[7]  = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 0, 2, 2, 0, 1, 1};
    vt[8]  = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 0, 2, 2, 0, 1, 1};
    vt[9]  = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 0, 2, 2, 0, 1, 1};
    vt[10] = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1, 2, 2, 1, 1, 1};
    vt[11] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1, 2, 2, 0, 1, 1};
    vt[12] = '{1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0};

    for (int i = 0; i < 13; i++) begin
      step(vt[i].rst, vt[i].run, vt[i].sel, vt[i].im, vt[i].ih, 1'b0, 1'b0, 1'b0);
      chk($sformatf("vec%0d_sec", i), sec, vt[i].e_sec);
      chk($sformatf("vec%0d_min", i), min, vt[i].e_min);
      chk($sformatf("vec%0d_hour", i), hour24, vt[i].e_hour);
      chk($sformatf("vec%0d_sec_tick", i), st, vt[i].e_st);
      chk($sformatf("vec%0d_amin", i), amin, vt[i].e_amin);
      chk($sformatf("vec%0d_ahour", i), ahour24, vt[i].e_ahour);
    end
    chk("reset_hour12", hour12, 12);
    chk("reset_pm12", pm12, 0);
    chk("reset_alarm_active", aa, 0);

    // One minute of running: tick cadence and the single minute carry.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    first = -1; nst = 0; nmt = 0; bad_seq = 0;
    for (int c = 1; c <= 240; c++) begin
      step(0, 1, 0, 0, 0, 0, 0, 0);
      if (st) begin
        nst++;
        if (first < 0) first = c;
        if (int'(sec) != nst % 60) bad_seq++;
      end
      if (mt) nmt++;
    end
    chk("first_sec_tick_cycle", first, 4);
    chk("sec_tick_count", nst, 60);
    chk("min_tick_count", nmt, 1);
    chk("sec_sequence_errors", bad_seq, 0);
    chk("minute_after_60s", min, 1);
    chk("sec_after_60s", sec, 0);

    // Midnight rollover from 23:59:58.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 23; i++) step(0, 0, 1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 36; i++) step(0, 0, 1, 1, 0, 0, 0, 0);
    chk("preset_hour", hour24, 23);
    chk("preset_min", min, 59);
    for (int c = 1; c <= 232; c++) step(0, 1, 0, 0, 0, 0, 0, 0);
    chk("pre_roll_sec", sec, 58);
    for (int c = 1; c <= 8; c++) begin
      step(0, 1, 0, 0, 0, 0, 0, 0);
      if (c == 4) begin
        chk("t2359_59_sec", sec, 59);
        chk("t2359_59_tick", st, 1);
        chk("t2359_59_min_tick", mt, 0);
        chk("t2359_59_hour12", hour12, 11);
        chk("t2359_59_pm12", pm12, 1);
      end
      if (c == 8) begin
        chk("midnight_hour", hour24, 0);
        chk("midnight_min", min, 0);
        chk("midnight_sec", sec, 0);
        chk("midnight_sec_tick", st, 1);
        chk("midnight_min_tick", mt, 1);
        chk("midnight_hour_tick", ht, 1);
        chk("midnight_hour12", hour12, 12);
        chk("midnight_pm12", pm12, 0);
      end
    end

    // 12-hour mapping at 0, 12 and 13.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("h0_hour12", hour12, 12);
    chk("h0_pm12", pm12, 0);
    for (int i = 0; i < 12; i++) step(0, 0, 1, 0, 1, 0, 0, 0);
    chk("h12_hour12", hour12, 12);
    chk("h12_pm12", pm12, 1);
    step(0, 0, 1, 0, 1, 0, 0, 0);
    chk("h13_hour12", hour12, 1);
    chk("h13_pm12", pm12, 1);
    chk("h13_hour24", hour24, 13);

    // Alarm at 00:02: rise after the match tick, ring timeout after 3 ticks.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 2, 1, 0, 1, 0, 0);
    step(0, 0, 2, 1, 0, 1, 0, 0);
    chk("alarm_min_set", amin, 2);
    tick_cyc = -1; rise = -1; fall = -1;
    for (int c = 1; c <= 600; c++) begin
      step(0, 1, 0, 0, 0, 1, 0, 0);
      if (st && min == 6'd2 && sec == 6'd0 && tick_cyc < 0) tick_cyc = c;
      if (aa && rise < 0) rise = c;
      if (rise > 0 && !aa && fall < 0) fall = c;
    end
    chk("match_tick_cycle", tick_cyc, 480);
    chk("alarm_rise_cycle", rise, 481);
    chk("alarm_fall_cycle", fall, 493);

    // Snooze, re-ring on the next minute, then snooze+off together.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 2, 1, 0, 1, 0, 0);
    step(0, 0, 2, 1, 0, 1, 0, 0);
    rise = -1; cyc = 0;
    for (int c = 1; c <= 600; c++) begin
      step(0, 1, 0, 0, 0, 1, 0, 0);
      cyc++;
      if (aa) begin rise = c; break; end
    end
    chk("snooze_ring_rise", rise, 481);
    step(0, 1, 0, 0, 0, 1, 1, 0);
    cyc++;
    chk("snoozed_alarm_low", aa, 0);
    mt_cyc = -1; rise = -1;
    for (int c = 0; c < 400; c++) begin
      step(0, 1, 0, 0, 0, 1, 0, 0);
      cyc++;
      if (mt && mt_cyc < 0) mt_cyc = cyc;
      if (aa) begin rise = cyc; break; end
    end
    chk("snooze_min_tick_cycle", mt_cyc, 720);
    chk("snooze_rering_cycle", rise, 721);
    step(0, 1, 0, 0, 0, 1, 1, 1);
    chk("off_wins_alarm_low", aa, 0);
    rering = 0;
    for (int c = 0; c < 400; c++) begin
      step(0, 1, 0, 0, 0, 1, 0, 0);
      if (aa) rering++;
    end
    chk("no_rering_after_off", rering, 0);

    // Set time 05:59 -> 06:00 with both pulses together; no ticks in set mode.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 10; c++) step(0, 1, 0, 0, 0, 0, 0, 0);
    chk("pre_set_sec", sec, 2);
    any_tick = 0;
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 1, 1, 1, 0, 0, 0);
      if (i == 0) chk("set_clears_sec", sec, 0);
      any_tick += int'(st) + int'(mt) + int'(ht);
    end
    for (int i = 0; i < 54; i++) begin
      step(0, 1, 1, 1, 0, 0, 0, 0);
      any_tick += int'(st) + int'(mt) + int'(ht);
    end
    chk("set_0559_hour", hour24, 5);
    chk("set_0559_min", min, 59);
    step(0, 1, 1, 1, 1, 0, 0, 0);
    any_tick += int'(st) + int'(mt) + int'(ht);
    chk("set_0600_hour", hour24, 6);
    chk("set_0600_min", min, 0);
    chk("set_0600_sec", sec, 0);
    chk("set_mode_ticks", any_tick, 0);

    // Randomized run against the model, starting with the alarm at 00:02.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 2, 1, 0, 1, 0, 0);
    step(0, 0, 2, 1, 0, 1, 0, 0);
    check_model();
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 999);
      rs = (r < 970) ? 2'd0 : (r < 973) ? 2'd1 : (r < 990) ? 2'd2 : 2'd3;
      step($urandom_range(0, 1999) == 0, $urandom_range(0, 9) != 0, rs,
           $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 19) != 0, $urandom_range(0, 49) == 0,
           $urandom_range(0, 99) == 0);
      check_model();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alarm_clock_core.md
# alarm_clock_core

Parametrised timekeeping and alarm engine for the alarm-clock design: a cycle prescaler feeds cascaded second/minute/hour counters, with a selectable 12/24-hour presentation, a settable time and alarm, and an alarm state machine with ring timeout and snooze. It replaces the fixed single-purpose counter chain at the top level. Its outputs drive the seven-segment display driver and the status LEDs.

## Interface
Parameters:
- TICK_DIV, 100_000_000: clk cycles per second; must be ≥ 2.
- HOUR_24, 1: 1 = hour output 0–23; 0 = 12-hour output 1–12 with pm flag.
- RING_SEC, 60: seconds the alarm rings before auto-stopping; range 1–255.
- SNOOZE_MIN, 5: snooze length in minutes; range 1–59.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- run  in  1  1 = time advances; 0 = prescaler and time frozen.
- set_sel  in  2  0 = normal, 1 = set time, 2 = set alarm, 3 = treated as 0.
- inc_min  in  1  one-cycle pulse: +1 minute of the selected target.
- inc_hour  in  1  one-cycle pulse: +1 hour of the selected target.
- alarm_en  in  1  level: alarm armed.
- snooze  in  1  one-cycle pulse.
- alarm_off  in  1  one-cycle pulse.
- sec  out  6  seconds 0–59.
- min  out  6  minutes 0–59.
- hour  out  5  hour per HOUR_24.
- pm  out  1  1 when internal hour ≥ 12; valid in both modes.
- alarm_min  out  6; alarm_hour  out  5  (same hour format as hour).
- sec_tick, min_tick, hour_tick  out  1  one-cycle carry strobes.
- alarm_active  out  1  alarm sounding.

## Operation
- Internal hour is always 0–23. 12-hour output maps 0→12, 13–23→1–11, and 1–12 unchanged.
- Prescaler: width $clog2(TICK_DIV). It counts 0..TICK_DIV-1 while run=1 and set_sel≠1, then wraps.
- On wrap, sec increments and sec_tick pulses. sec 59→0 increments min and pulses min_tick. min 59→0 increments hour and pulses hour_tick. Hour 23→0 wraps silently.
- Set time (set_sel=1):
  - Prescaler and sec are held at 0; no ticks.
  - inc_min steps min mod 60 without carry. inc_hour steps hour mod 24.
  - Both pulses in the same cycle apply both.
- Set alarm (set_sel=2): inc_min and inc_hour act the same way on alarm_min/alarm_hour. Time keeps running.
- In normal mode, inc pulses are ignored.
- Alarm match: a sec_tick that produces sec=0 while hour:min equals alarm_hour:alarm_min, with alarm_en=1 and set_sel≠1.
- Alarm FSM (states IDLE, RINGING, SNOOZED):
  - IDLE→RINGING on match. Ring-second counter loads 0.
  - RINGING→IDLE on alarm_off, on alarm_en=0, or when the ring counter reaches RING_SEC sec_ticks.
  - RINGING→SNOOZED on snooze. Snooze counter loads 0.
  - SNOOZED→RINGING after SNOOZE_MIN min_ticks.
  - SNOOZED→IDLE on alarm_off or alarm_en=0.
  - alarm_off and snooze in the same cycle: alarm_off wins.
  - A match while RINGING or SNOOZED is ignored.
- alarm_active = 1 only in RINGING.

## Timing
- All outputs are registered.
- Reset values: time 00:00:00, alarm 00:00, hour output 0 in 24-hour mode and 12 in 12-hour mode, pm=0, all ticks 0, FSM IDLE, alarm_active 0.
- rst asserted mid-operation clears all state on the next edge and overrides every other input.
- sec_tick is high in the same cycle the new sec value appears. It follows the prescaler terminal-count cycle by 1 clk.
- min_tick and hour_tick are coincident with sec_tick on their rollover cycles.
- Any tick fires at most once per TICK_DIV cycles.
- alarm_active rises 1 cycle after the matching sec_tick and falls 1 cycle after alarm_off.
- inc pulses take effect on the next edge.
- Dropping run freezes the prescaler value; restarting resumes the count, it does not restart it.

## Structure
- Package clock_pkg holds:
  - The alarm_state_t enum (IDLE, RINGING, SNOOZED).
  - Constants SEC_W=6, MIN_W=6, HOUR_W=5.
  - Set-select encodings SEL_NONE, SEL_TIME, SEL_ALARM.
- Sub-module mod_counter (parameters MOD and W; ports clk, rst, clr, inc, value, carry), instantiated for prescaler, sec, min, hour, and both alarm fields.
- FSM and 12/24-hour mapping live in the top of the block.

## Test plan
All scenarios use TICK_DIV=4.
- Reset, then run=1 for 4×60 cycles → sec cycles 0..59, one min_tick; min=1; first sec_tick on cycle 4 after reset release.
- Preload 23:59:58 via set mode, run for 8 cycles → 23:59:59, then 00:00:00 with min_tick and hour_tick coincident on the same cycle.
- HOUR_24=0, set internal hour 0, 12, 13 → hour output 12/pm=0, 12/pm=1, 1/pm=1.
- Alarm 00:02, alarm_en=1, run from 00:00:00 → alarm_active rises 1 cycle after the sec_tick reaching 00:02:00; with RING_SEC=3 it falls after the 3rd subsequent sec_tick.
- While RINGING, assert snooze with SNOOZE_MIN=1 → alarm_active low; it re-rises 1 cycle after the next min_tick. Then assert snooze and alarm_off together → IDLE, no re-ring.
- Set time with inc_min and inc_hour together from 05:59 → 06:00 with no carry artefacts; sec stays 0 and no ticks occur while set_sel=1.
